// File: rtl/router_pkg.sv
// ============================================================================
// router_pkg : constants, state encoding and helpers shared by the router FSM,
//              synchronizer and register blocks.            Revision: 1.0
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int          NUM_PORTS    = 3;
    localparam int          ADDR_W       = 2;
    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    // Selects one per-port flag; the invalid address selects nothing.
    function automatic logic port_sel(input logic [NUM_PORTS-1:0] flags,
                                      input logic [ADDR_W-1:0]    sel);
        logic hit;
        hit = 1'b0;
        case (sel)
            2'd0:    hit = flags[0];
            2'd1:    hit = flags[1];
            2'd2:    hit = flags[2];
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/router_fsm.sv
// ============================================================================
// router_fsm : packet-level control FSM of the 1-to-3 router; Moore strobes
//              drive the register block and FIFO write enable. Revision: 1.0
// ============================================================================
`default_nettype none

module router_fsm
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg,
    output logic       busy
);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_soft_reset;
    logic                w_empty_din;
    logic                w_empty_addr;
    logic                w_soft_reset_addr;

    assign w_empty           = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign w_soft_reset      = {soft_reset_2, soft_reset_1, soft_reset_0};
    assign w_empty_din       = port_sel(w_empty, data_in);
    assign w_empty_addr      = port_sel(w_empty, r_addr);
    assign w_soft_reset_addr = port_sel(w_soft_reset, r_addr);

    // Next-state logic; the addressed port's soft reset overrides everything.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            DECODE_ADDRESS: begin
                if (pkt_valid && (data_in != INVALID_ADDR))
                    w_next_state = w_empty_din ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            WAIT_TILL_EMPTY: begin
                if (w_empty_addr)
                    w_next_state = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: w_next_state = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)
                    w_next_state = FIFO_FULL_STATE;
                else if (!pkt_valid)
                    w_next_state = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full)
                    w_next_state = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)
                    w_next_state = DECODE_ADDRESS;
                else if (low_pkt_valid)
                    w_next_state = LOAD_PARITY;
                else
                    w_next_state = LOAD_DATA;
            end
            LOAD_PARITY: w_next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
            default: w_next_state = DECODE_ADDRESS;
        endcase
        if (w_soft_reset_addr)
            w_next_state = DECODE_ADDRESS;
    end

    always_ff @(posedge clock) begin
        if (!resetn)
            r_state <= DECODE_ADDRESS;
        else
            r_state <= w_next_state;
    end

    // The header address is latched on the same edge that leaves decode.
    always_ff @(posedge clock) begin
        if (!resetn)
            r_addr <= INVALID_ADDR;
        else if ((r_state == DECODE_ADDRESS) && (w_next_state != DECODE_ADDRESS))
            r_addr <= data_in;
    end

    always_comb begin
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        busy          = 1'b1;
        case (r_state)
            DECODE_ADDRESS: begin
                detect_add = 1'b1;
                busy       = 1'b0;
            end
            LOAD_FIRST_DATA: lfd_state = 1'b1;
            LOAD_DATA: begin
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
                busy          = 1'b0;
            end
            LOAD_PARITY: write_enb_reg = 1'b1;
            FIFO_FULL_STATE: full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            CHECK_PARITY_ERROR: rst_int_reg = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_router_fsm.sv
// ============================================================================
// tb_router_fsm : directed stimulus against a behavioural packet-flow model of
//                 router_fsm, compared every cycle.          Revision: 1.0
// ============================================================================
`default_nettype none

module tb_router_fsm;

    logic       clock;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;

    router_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Output vector order: detect_add lfd ld laf full write_enb rst_int busy
    localparam logic [7:0] O_DA   = 8'b1000_0000;
    localparam logic [7:0] O_LFD  = 8'b0100_0001;
    localparam logic [7:0] O_LD   = 8'b0010_0100;
    localparam logic [7:0] O_LAF  = 8'b0001_0101;
    localparam logic [7:0] O_FULL = 8'b0000_1001;
    localparam logic [7:0] O_LP   = 8'b0000_0101;
    localparam logic [7:0] O_WTE  = 8'b0000_0001;
    localparam logic [7:0] O_CPE  = 8'b0000_0011;

    int n_checks = 0;
    int n_fail   = 0;
    bit started  = 0;

    // Model: the current phase of the packet flow, kept as its expected output word.
    logic [7:0] m_phase;
    int         m_addr;
    logic [3:0] m_empty;
    logic [3:0] m_sr;

    function automatic logic [7:0] dut_out();
        return {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};
    endfunction

    always @(posedge clock) begin
        m_empty = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
        m_sr    = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
        if (!resetn) begin
            m_phase = O_DA;
            m_addr  = 3;
        end else if (m_sr[m_addr]) begin
            m_phase = O_DA;
        end else if (m_phase == O_DA) begin
            if (pkt_valid && data_in != 2'd3) begin
                m_addr  = int'(data_in);
                m_phase = m_empty[m_addr] ? O_LFD : O_WTE;
            end
        end else if (m_phase == O_WTE) begin
            if (m_empty[m_addr]) m_phase = O_LFD;
        end else if (m_phase == O_LFD) begin
            m_phase = O_LD;
        end else if (m_phase == O_LD) begin
            if (fifo_full)       m_phase = O_FULL;
            else if (!pkt_valid) m_phase = O_LP;
        end else if (m_phase == O_FULL) begin
            if (!fifo_full) m_phase = O_LAF;
        end else if (m_phase == O_LAF) begin
            m_phase = parity_done ? O_DA : (low_pkt_valid ? O_LP : O_LD);
        end else if (m_phase == O_LP) begin
            m_phase = O_CPE;
        end else if (m_phase == O_CPE) begin
            m_phase = fifo_full ? O_FULL : O_DA;
        end
    end

    always @(negedge clock) begin
        if (started) begin
            n_checks++;
            if (dut_out() !== m_phase) begin
                n_fail++;
                $display("FAIL cycle_compare t=%0t: outputs %b, model requires %b",
                         $time, dut_out(), m_phase);
            end
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Hand-computed expectation, applied to both the DUT and the model.
    task automatic expect_out(input string name, input logic [7:0] lit);
        n_checks += 2;
        if (dut_out() !== lit) begin
            n_fail++;
            $display("FAIL %s: dut outputs %b, required %b", name, dut_out(), lit);
        end
        if (m_phase !== lit) begin
            n_fail++;
            $display("FAIL %s_model: model outputs %b, required %b", name, m_phase, lit);
        end
    endtask

    initial begin
        resetn = 0; pkt_valid = 0; data_in = 2'd0; fifo_full = 0;
        fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
        parity_done = 0; low_pkt_valid = 0;
        tick();
        started = 1;
        tick();
        expect_out("reset_state", O_DA);
        resetn = 1;
        tick();
        expect_out("idle_decode", O_DA);

        // Header to port 1 with its FIFO empty, 4-byte payload, parity.
        pkt_valid = 1; data_in = 2'd1;
        tick();
        expect_out("first_data_port1", O_LFD);
        data_in = 2'd0;
        tick();
        expect_out("load_data", O_LD);
        tick(3);
        expect_out("payload_ld", O_LD);
        pkt_valid = 0;
        tick();
        expect_out("load_parity", O_LP);
        tick();
        expect_out("check_parity", O_CPE);
        tick();
        expect_out("back_to_decode", O_DA);

        // Port 0 busy for 5 cycles.
        fifo_empty_0 = 0; pkt_valid = 1; data_in = 2'd0;
        tick();
        expect_out("wait_empty_enter", O_WTE);
        tick(4);
        expect_out("wait_empty_hold", O_WTE);
        fifo_empty_0 = 1;
        tick();
        expect_out("wait_empty_release", O_LFD);
        tick();
        expect_out("load_data_p0", O_LD);

        // FIFO full for 3 cycles, then load-after-full into parity.
        fifo_full = 1;
        tick(3);
        expect_out("fifo_full_hold", O_FULL);
        fifo_full = 0; pkt_valid = 0;
        tick();
        expect_out("load_after_full", O_LAF);
        low_pkt_valid = 1;
        tick();
        expect_out("laf_to_parity", O_LP);
        low_pkt_valid = 0; fifo_full = 1;
        tick();
        expect_out("check_parity2", O_CPE);
        tick();
        expect_out("cpe_full", O_FULL);
        fifo_full = 0;
        tick();
        expect_out("laf_again", O_LAF);
        pkt_valid = 1;
        tick();
        expect_out("laf_to_ld", O_LD);
        fifo_full = 1;
        tick();
        fifo_full = 0;
        tick();
        parity_done = 1; low_pkt_valid = 1;
        tick();
        expect_out("laf_parity_done", O_DA);
        parity_done = 0; low_pkt_valid = 0;

        // Port 2 packet; only soft_reset_2 may abort it.
        data_in = 2'd2;
        tick(2);
        expect_out("load_data_p2", O_LD);
        soft_reset_0 = 1; soft_reset_1 = 1;
        tick();
        expect_out("foreign_soft_reset", O_LD);
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 1;
        tick();
        expect_out("own_soft_reset", O_DA);
        soft_reset_2 = 0;

        // Invalid header is ignored and leaves addr at 2.
        data_in = 2'd3;
        tick(3);
        expect_out("invalid_addr", O_DA);
        data_in = 2'd1; soft_reset_2 = 1;
        tick();
        expect_out("addr_kept_2", O_DA);
        soft_reset_2 = 0;
        tick(2);
        expect_out("load_data_p1", O_LD);

        // Hard reset mid-packet beats soft reset; addr returns to 3.
        resetn = 0; soft_reset_1 = 1;
        tick();
        expect_out("reset_mid_packet", O_DA);
        resetn = 1; soft_reset_0 = 1; soft_reset_1 = 1; soft_reset_2 = 1; data_in = 2'd0;
        tick();
        expect_out("addr_is_3", O_LFD);
        soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0; pkt_valid = 0;
        tick(4);
        expect_out("final_decode", O_DA);

        @(negedge clock);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
